// File: rtl/program_memory_loader_pkg.sv
// Shared types and constants for the framed program-memory loader:
// FSM state encoding, error codes and state-class helpers.
package program_memory_loader_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        SYNC   = 4'd1,
        LEN_HI = 4'd2,
        LEN_LO = 4'd3,
        DATA   = 4'd4,
        WRITE  = 4'd5,
        CHECK  = 4'd6,
        DONE   = 4'd7,
        ERROR  = 4'd8
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic state_is_timed(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
    endfunction

    function automatic logic state_accepts_bytes(input state_t s);
        return (s == SYNC) || state_is_timed(s);
    endfunction

    function automatic logic state_holds_cpu(input state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/program_memory_loader_byte_word_assembler.sv
// Packs four bytes MSB-first into a word and keeps a running XOR checksum.
// Outputs look ahead by one byte so the caller can act on the byte being shifted.
module program_memory_loader_byte_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete,
    output logic [7:0]  checksum
);

    logic [31:0] word_q;
    logic [1:0]  count_q;
    logic [7:0]  csum_q;

    // Shift register, byte counter and checksum accumulator
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_q  <= 32'd0;
            count_q <= 2'd0;
            csum_q  <= 8'd0;
        end else if (shift_en) begin
            word_q  <= {word_q[23:0], byte_in};
            count_q <= count_q + 2'd1;
            csum_q  <= csum_q ^ byte_in;
        end else begin
            word_q  <= word_q;
            count_q <= count_q;
            csum_q  <= csum_q;
        end
    end

    assign word          = shift_en ? {word_q[23:0], byte_in} : word_q;
    assign word_complete = shift_en && (count_q == 2'd3);
    assign checksum      = shift_en ? (csum_q ^ byte_in) : csum_q;

endmodule

// File: rtl/program_memory_loader.sv
// Parses a framed byte stream (sync, length, big-endian words, XOR checksum)
// into one-cycle program-memory writes while holding the CPU in reset.
module program_memory_loader
    import program_memory_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0040_0000,
    parameter int          MEMORY_DEPTH   = 300,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LoadStart,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        CPUHold,
    output logic        Done,
    output logic        Error,
    output logic [1:0]  ErrorCode,
    output logic [15:0] WordsLoaded
);

    localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         err_code_d, err_code_q;
    logic               byte_ready_q, mem_write_q, cpu_hold_q, done_q, error_q;
    logic [31:0]        mem_addr_q, mem_data_q;
    logic [15:0]        words_q, len_q, len_s;
    logic [IDLE_W-1:0]  idle_q;
    logic               accept_s, timeout_s, asm_clear_s, asm_shift_s, asm_complete_s;
    logic [31:0]        asm_word_s;
    logic [7:0]         asm_csum_s;

    assign accept_s    = ByteValid && byte_ready_q;
    assign timeout_s   = state_is_timed(state_q) && !accept_s && (idle_q == IDLE_LIMIT);
    assign len_s       = {len_q[15:8], ByteIn};
    assign asm_clear_s = accept_s && (state_q == LEN_LO);
    assign asm_shift_s = accept_s && (state_q == DATA);

    program_memory_loader_byte_word_assembler u_byte_word_assembler (
        .clk           (clk),
        .reset         (reset),
        .clear         (asm_clear_s),
        .shift_en      (asm_shift_s),
        .byte_in       (ByteIn),
        .word          (asm_word_s),
        .word_complete (asm_complete_s),
        .checksum      (asm_csum_s)
    );

    // Next-state decode; err_code_d is only meaningful on entry to ERROR
    always_comb begin
        state_d    = state_q;
        err_code_d = ERR_NONE;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (LoadStart) state_d = SYNC;
                else           state_d = state_q;
            end
            SYNC: begin
                if (accept_s && (ByteIn == SYNC_BYTE)) state_d = LEN_HI;
                else                                   state_d = SYNC;
            end
            LEN_HI: begin
                if (accept_s)       state_d = LEN_LO;
                else if (timeout_s) begin state_d = ERROR; err_code_d = ERR_TIMEOUT; end
                else                state_d = LEN_HI;
            end
            LEN_LO: begin
                if (accept_s) begin
                    if ((len_s == 16'd0) || (len_s > 16'(MEMORY_DEPTH))) begin
                        state_d    = ERROR;
                        err_code_d = ERR_LEN;
                    end else begin
                        state_d = DATA;
                    end
                end else if (timeout_s) begin
                    state_d    = ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    state_d = LEN_LO;
                end
            end
            DATA: begin
                if (asm_complete_s) state_d = WRITE;
                else if (timeout_s) begin state_d = ERROR; err_code_d = ERR_TIMEOUT; end
                else                state_d = DATA;
            end
            WRITE: begin
                if ((words_q + 16'd1) == len_q) state_d = CHECK;
                else                            state_d = DATA;
            end
            CHECK: begin
                if (accept_s) begin
                    if (ByteIn == asm_csum_s) state_d = DONE;
                    else begin state_d = ERROR; err_code_d = ERR_CSUM; end
                end else if (timeout_s) begin
                    state_d    = ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    state_d = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and all registered outputs, loaded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_ready_q <= 1'b0;
            mem_write_q  <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            words_q      <= 16'd0;
            len_q        <= 16'd0;
            mem_addr_q   <= 32'd0;
            mem_data_q   <= 32'd0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= state_accepts_bytes(state_d);
            cpu_hold_q   <= state_holds_cpu(state_d);
            mem_write_q  <= (state_d == WRITE);
            if (state_d == WRITE) begin
                mem_addr_q <= BASE_ADDRESS + {14'd0, words_q, 2'b00};
                mem_data_q <= asm_word_s;
            end
            if (accept_s && (state_q == LEN_HI)) len_q[15:8] <= ByteIn;
            if (accept_s && (state_q == LEN_LO)) len_q[7:0]  <= ByteIn;
            if (accept_s || (state_d != state_q)) idle_q <= '0;
            else if (state_is_timed(state_q))     idle_q <= idle_q + IDLE_W'(1);
            if ((state_d == SYNC) && (state_q != SYNC)) begin
                done_q     <= 1'b0;
                error_q    <= 1'b0;
                err_code_q <= ERR_NONE;
                words_q    <= 16'd0;
            end else begin
                if (state_q == WRITE) words_q <= words_q + 16'd1;
                if (state_d == DONE)  done_q  <= 1'b1;
                if ((state_d == ERROR) && (state_q != ERROR)) begin
                    error_q    <= 1'b1;
                    err_code_q <= err_code_d;
                end
            end
        end
    end

    assign ByteReady    = byte_ready_q;
    assign MemWrite     = mem_write_q;
    assign MemAddress   = mem_addr_q;
    assign MemWriteData = mem_data_q;
    assign CPUHold      = cpu_hold_q;
    assign Done         = done_q;
    assign Error        = error_q;
    assign ErrorCode    = err_code_q;
    assign WordsLoaded  = words_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Randomised scoreboard bench for program_memory_loader: a frame parser model
// predicts writes and final status; a monitor checks every MemWrite it sees.
module tb_program_memory_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic done; logic err; logic [1:0] code; logic [15:0] words; } status_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        LoadStart = 1'b0;
    logic [7:0]  ByteIn = 8'd0;
    logic        ByteValid = 1'b0;
    logic        ByteReady, MemWrite, CPUHold, Done, Error;
    logic [31:0] MemAddress, MemWriteData;
    logic [1:0]  ErrorCode;
    logic [15:0] WordsLoaded;

    int  vectors = 0;
    int  misc = 0;
    wr_t exp_q[$];

    program_memory_loader #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .reset(reset), .LoadStart(LoadStart), .ByteIn(ByteIn),
        .ByteValid(ByteValid), .ByteReady(ByteReady), .MemWrite(MemWrite),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData), .CPUHold(CPUHold),
        .Done(Done), .Error(Error), .ErrorCode(ErrorCode), .WordsLoaded(WordsLoaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (MemWrite === 1'b1) begin
                chk("ready_low_in_write", {31'd0, ByteReady}, 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++; misc++;
                    $display("FAIL unexpected_write: got %h:%h expected none", MemAddress, MemWriteData);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", MemAddress, e.addr);
                    chk("write_data", MemWriteData, e.data);
                end
            end
        end
    end

    // Reference model: parse a whole frame the way the format defines it
    task automatic model(input bq_t q, output status_t s);
        int i, n;
        logic [7:0] x;
        wr_t e;
        s = '0;
        i = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        n = int'({q[i+1], q[i+2]});
        i = i + 3;
        if (n == 0 || n > 300) begin
            s.err = 1'b1; s.code = 2'd1;
        end else begin
            x = 8'd0;
            for (int k = 0; k < n; k++) begin
                e.addr = 32'h0040_0000 + 32'(4 * k);
                e.data = {q[i], q[i+1], q[i+2], q[i+3]};
                x = x ^ q[i] ^ q[i+1] ^ q[i+2] ^ q[i+3];
                exp_q.push_back(e);
                i = i + 4;
            end
            s.words = 16'(n);
            if (q[i] == x) s.done = 1'b1;
            else begin s.err = 1'b1; s.code = 2'd2; end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        logic rdy;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        ByteIn = b; ByteValid = 1'b1; budget = 0;
        do begin
            @(negedge clk); rdy = ByteReady;
            @(posedge clk); #1;
            budget++;
        end while (!rdy && budget < 100);
        ByteValid = 1'b0;
        chk("byte_accepted", {31'd0, rdy}, 32'd1);
    endtask

    task automatic load_start();
        LoadStart = 1'b1;
        @(posedge clk); #1;
        LoadStart = 1'b0;
        chk("hold_after_start", {31'd0, CPUHold}, 32'd1);
        chk("ready_after_start", {31'd0, ByteReady}, 32'd1);
    endtask

    task automatic check_status(input string tag, input status_t s);
        int budget = 0;
        while (!(Done === 1'b1 || Error === 1'b1) && budget < 20) begin
            @(negedge clk); budget++;
        end
        chk({tag, ".done"}, {31'd0, Done}, {31'd0, s.done});
        chk({tag, ".error"}, {31'd0, Error}, {31'd0, s.err});
        chk({tag, ".code"}, {30'd0, ErrorCode}, {30'd0, s.code});
        chk({tag, ".words"}, {16'd0, WordsLoaded}, {16'd0, s.words});
        chk({tag, ".hold"}, {31'd0, CPUHold}, {31'd0, ~s.done});
        chk({tag, ".pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_frame(input string tag, input bq_t q, input int gapmax);
        status_t s;
        load_start();
        model(q, s);
        foreach (q[i]) send_byte(q[i], $urandom_range(0, gapmax));
        check_status(tag, s);
    endtask

    task automatic build_random(output bq_t q);
        int n, sel;
        logic [7:0] b, x;
        q = {};
        repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            q.push_back(b);
        end
        q.push_back(8'hA5);
        sel = $urandom_range(0, 9);
        if (sel == 0) begin
            n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(301, 65535);
            q.push_back(8'(n >> 8)); q.push_back(8'(n));
        end else begin
            n = $urandom_range(1, 6);
            q.push_back(8'(n >> 8)); q.push_back(8'(n));
            x = 8'd0;
            repeat (4 * n) begin
                b = 8'($urandom_range(0, 255));
                x = x ^ b;
                q.push_back(b);
            end
            if (sel == 1) q.push_back(x ^ 8'(1 << $urandom_range(0, 7)));
            else          q.push_back(x);
        end
    endtask

    initial begin
        bq_t q;
        status_t s;
        wr_t e;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", {31'd0, ByteReady}, 32'd0);
        chk("rst.write", {31'd0, MemWrite}, 32'd0);
        chk("rst.hold", {31'd0, CPUHold}, 32'd0);
        chk("rst.done_err", {30'd0, Done, Error}, 32'd0);
        chk("rst.code_words", {14'd0, ErrorCode, WordsLoaded}, 32'd0);
        chk("rst.addr", MemAddress, 32'd0);
        chk("rst.data", MemWriteData, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic frame with hand-computed expectations
        e.addr = 32'h0040_0000; e.data = 32'h2008_0005; exp_q.push_back(e);
        e.addr = 32'h0040_0004; e.data = 32'h2009_000A; exp_q.push_back(e);
        q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        load_start();
        foreach (q[i]) send_byte(q[i], 0);
        s = '0; s.done = 1'b1; s.words = 16'd2;
        check_status("basic", s);

        q = '{8'h11, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        run_frame("sync_hunt", q, 2);
        q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0F};
        run_frame("bad_csum", q, 2);
        q = '{8'hA5, 8'h00, 8'h00};
        run_frame("len_zero", q, 1);
        q = '{8'hA5, 8'h01, 8'h2D};
        run_frame("len_301", q, 1);

        // Idle timeout inside the data phase: 49 idle cycles are tolerated, 50 are not
        load_start();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        repeat (49) @(posedge clk);
        #1;
        chk("timeout.not_early", {31'd0, Error}, 32'd0);
        @(posedge clk); #1;
        s = '0; s.err = 1'b1; s.code = 2'd3;
        check_status("timeout", s);

        q = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        load_start();
        model(q, s);
        foreach (q[i]) send_byte(q[i], (i == 3) ? 49 : 0);
        check_status("idle49", s);

        // Reset after the second data byte of a frame
        load_start();
        q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        foreach (q[i]) send_byte(q[i], 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst.ready", {31'd0, ByteReady}, 32'd0);
        chk("midrst.hold", {31'd0, CPUHold}, 32'd0);
        chk("midrst.flags", {28'd0, Done, Error, ErrorCode}, 32'd0);
        chk("midrst.words", {16'd0, WordsLoaded}, 32'd0);
        chk("midrst.addr", MemAddress, 32'd0);
        q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07, 8'h07};
        run_frame("after_rst", q, 1);

        // Largest accepted frame
        q = '{8'hA5, 8'h01, 8'h2C};
        repeat (1200) q.push_back(8'($urandom_range(0, 255)));
        q.push_back(8'($urandom_range(0, 255)));
        run_frame("depth300", q, 0);

        for (int f = 0; f < 20; f++) begin
            build_random(q);
            run_frame($sformatf("rand%0d", f), q, 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
